control_unit: RTL

Multi-cycle fetch/decode/execute controller for the 8-bit datapath, sitting directly upstream of the 3-read/1-write register file. It fetches 16-bit instructions over a req/ack handshake, drives the register-file read addresses, and latches the returned operands. It computes the result with an internal 8-bit ALU and drives the register file's write port (`EscReg`, `WriteData`, `RegWrite`). It also owns the program counter and branch resolution.

---
 rtl/cpu_pkg.sv | 51 +++++
 rtl/control_unit_if.sv | 28 ++
 rtl/alu8.sv | 29 ++
 rtl/control_unit.sv | 127 ++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared types and constants for the 8-bit fetch/decode/execute controller.
package cpu_pkg;

  localparam int unsigned DATA_W  = 8;
  localparam int unsigned ADDR_W  = 3;
  localparam int unsigned INSTR_W = 16;
  localparam int unsigned PC_W    = 8;
  localparam int unsigned OP_W    = 4;

  localparam int unsigned OP_MSB  = 15;
  localparam int unsigned OP_LSB  = 12;
  localparam int unsigned RD_MSB  = 11;
  localparam int unsigned RD_LSB  = 9;
  localparam int unsigned RS1_MSB = 8;
  localparam int unsigned RS1_LSB = 6;
  localparam int unsigned RS2_MSB = 5;
  localparam int unsigned RS2_LSB = 3;
  localparam int unsigned RS3_MSB = 2;
  localparam int unsigned RS3_LSB = 0;
  localparam int unsigned IMM_MSB = 7;
  localparam int unsigned IMM_LSB = 0;

  typedef enum logic [OP_W-1:0] {
    OP_NOP  = 4'h0,
    OP_ADD  = 4'h1,
    OP_SUB  = 4'h2,
    OP_AND  = 4'h3,
    OP_OR   = 4'h4,
    OP_XOR  = 4'h5,
    OP_ADD3 = 4'h6,
    OP_LDI  = 4'h7,
    OP_BEZ  = 4'h8,
    OP_JMP  = 4'h9,
    OP_HALT = 4'hF
  } opcode_e;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH     = 3'd1,
    S_DECODE    = 3'd2,
    S_EXECUTE   = 3'd3,
    S_WRITEBACK = 3'd4,
    S_HALTED    = 3'd5
  } state_e;

  // Opcodes whose result goes through the register-file write port.
  function automatic logic writes_rd(input logic [OP_W-1:0] op);
    return (op >= OP_ADD) && (op <= OP_LDI);
  endfunction

endpackage

// File: rtl/control_unit_if.sv
// Instruction-fetch handshake and register-file port bundle.
interface control_unit_if;
  import cpu_pkg::*;

  logic                imem_req;
  logic [PC_W-1:0]     imem_addr;
  logic                imem_ack;
  logic [INSTR_W-1:0]  imem_data;
  logic [ADDR_W-1:0]   Read1;
  logic [ADDR_W-1:0]   Read2;
  logic [ADDR_W-1:0]   Read3;
  logic [DATA_W-1:0]   Data1;
  logic [DATA_W-1:0]   Data2;
  logic [DATA_W-1:0]   Data3;
  logic [ADDR_W-1:0]   EscReg;
  logic [DATA_W-1:0]   WriteData;
  logic                RegWrite;

  modport master (
    output imem_req, imem_addr, Read1, Read2, Read3, EscReg, WriteData, RegWrite,
    input  imem_ack, imem_data, Data1, Data2, Data3
  );

  modport slave (
    input  imem_req, imem_addr, Read1, Read2, Read3, EscReg, WriteData, RegWrite,
    output imem_ack, imem_data, Data1, Data2, Data3
  );
endinterface

// File: rtl/alu8.sv
// Combinational 8-bit ALU; zero flags a zero result (BEZ passes operand a through).
module alu8
  import cpu_pkg::*;
(
  input  logic [OP_W-1:0]   i_op,
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  input  logic [DATA_W-1:0] i_c,
  input  logic [DATA_W-1:0] i_imm,
  output logic [DATA_W-1:0] o_result,
  output logic              o_zero
);

  always_comb begin
    o_result = i_a;
    case (i_op)
      OP_ADD:  o_result = i_a + i_b;
      OP_SUB:  o_result = i_a - i_b;
      OP_AND:  o_result = i_a & i_b;
      OP_OR:   o_result = i_a | i_b;
      OP_XOR:  o_result = i_a ^ i_b;
      OP_ADD3: o_result = i_a + i_b + i_c;
      OP_LDI:  o_result = i_imm;
      default: o_result = i_a;
    endcase
    o_zero = (o_result == '0);
  end

endmodule

// File: rtl/control_unit.sv
// Multi-cycle fetch/decode/execute controller driving a 3-read/1-write register file.
module control_unit
  import cpu_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = 8'h00
) (
  input  logic              clock,
  input  logic              reset,
  control_unit_if.master    bus,
  output logic [PC_W-1:0]   pc,
  output logic              halted
);

  state_e              r_state;
  state_e              w_next_state;
  logic [PC_W-1:0]     r_pc;
  logic [INSTR_W-1:0]  r_ir;
  logic [DATA_W-1:0]   r_op1;
  logic [DATA_W-1:0]   r_op2;
  logic [DATA_W-1:0]   r_op3;
  logic [DATA_W-1:0]   r_result;
  logic                r_imem_req;
  logic                r_regwrite;
  logic                r_halted;

  logic [OP_W-1:0]     w_op;
  logic [ADDR_W-1:0]   w_rd;
  logic [ADDR_W-1:0]   w_rs1;
  logic [ADDR_W-1:0]   w_rs2;
  logic [ADDR_W-1:0]   w_rs3;
  logic [DATA_W-1:0]   w_imm;
  logic [DATA_W-1:0]   w_alu_result;
  logic                w_alu_zero;
  logic                w_fetch_done;
  logic                w_branch;

  assign w_op  = r_ir[OP_MSB:OP_LSB];
  assign w_rd  = r_ir[RD_MSB:RD_LSB];
  assign w_rs1 = r_ir[RS1_MSB:RS1_LSB];
  assign w_rs2 = r_ir[RS2_MSB:RS2_LSB];
  assign w_rs3 = r_ir[RS3_MSB:RS3_LSB];
  assign w_imm = r_ir[IMM_MSB:IMM_LSB];

  // Ack outside FETCH is ignored; the state qualifies the handshake.
  assign w_fetch_done = (r_state == S_FETCH) && bus.imem_ack;
  assign w_branch     = (w_op == OP_JMP) || ((w_op == OP_BEZ) && w_alu_zero);

  alu8 u_alu (
    .i_op     (w_op),
    .i_a      (r_op1),
    .i_b      (r_op2),
    .i_c      (r_op3),
    .i_imm    (w_imm),
    .o_result (w_alu_result),
    .o_zero   (w_alu_zero)
  );

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:      w_next_state = S_FETCH;
      S_FETCH:     if (bus.imem_ack) w_next_state = S_DECODE;
      S_DECODE:    w_next_state = S_EXECUTE;
      S_EXECUTE: begin
        if (w_op == OP_HALT)     w_next_state = S_HALTED;
        else if (writes_rd(w_op)) w_next_state = S_WRITEBACK;
        else                     w_next_state = S_FETCH;
      end
      S_WRITEBACK: w_next_state = S_FETCH;
      S_HALTED:    w_next_state = S_HALTED;
      default:     w_next_state = S_IDLE;
    endcase
  end

  // State and registered control outputs, decoded from the next state.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_imem_req <= 1'b0;
      r_regwrite <= 1'b0;
      r_halted   <= 1'b0;
    end else begin
      r_state    <= w_next_state;
      r_imem_req <= (w_next_state == S_FETCH);
      r_regwrite <= (w_next_state == S_WRITEBACK) && (w_rd != '0);
      r_halted   <= (w_next_state == S_HALTED);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_pc     <= RESET_PC;
      r_ir     <= '0;
      r_op1    <= '0;
      r_op2    <= '0;
      r_op3    <= '0;
      r_result <= '0;
    end else begin
      if (w_fetch_done) begin
        r_ir <= bus.imem_data;
        r_pc <= r_pc + PC_W'(1);
      end
      if (r_state == S_DECODE) begin
        r_op1 <= bus.Data1;
        r_op2 <= bus.Data2;
        r_op3 <= bus.Data3;
      end
      if (r_state == S_EXECUTE) begin
        r_result <= w_alu_result;
        if (w_branch) r_pc <= w_imm;
      end
    end
  end

  // BEZ tests R[rd], so the rd field is steered onto the first read port.
  assign bus.Read1     = (w_op == OP_BEZ) ? w_rd : w_rs1;
  assign bus.Read2     = w_rs2;
  assign bus.Read3     = w_rs3;
  assign bus.imem_req  = r_imem_req;
  assign bus.imem_addr = r_pc;
  assign bus.EscReg    = w_rd;
  assign bus.WriteData = r_result;
  assign bus.RegWrite  = r_regwrite;
  assign pc            = r_pc;
  assign halted        = r_halted;

endmodule
